button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end conditioner for raw push-button or switch inputs on the board.
- Synchronises the asynchronous pin into clk, debounces it with a 4-state FSM and a counter, and produces three outputs:
  - a clean level;
  - a one-cycle press pulse;
  - a one-cycle release pulse.
- Sits upstream of the flip-flop and state-machine blocks. Their clock-enable / data-capture events come from btn_press, never from a raw button.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples required to accept a level change (10 ms at 100 MHz); legal range is 1 and up.
- CNT_W, $clog2(DEBOUNCE_CYCLES) with a minimum of 1, width of the debounce counter (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn_in  input  1  raw asynchronous button/switch pin.
- btn_level  output  1  debounced level; 1 = pressed.
- nbtn_level  output  1  combinational inverse of btn_level.
- btn_press  output  1  registered one-cycle pulse on accepted 0->1.
- btn_release  output  1  registered one-cycle pulse on accepted 1->0.

Behaviour:
- Reset (rst_n=0 sampled at a rising edge):
  - sync1, sync2, counter, btn_level, btn_press and btn_release all go to 0; state goes to IDLE; nbtn_level=1.
  - Reset mid-count or while HIGH discards all progress. No release pulse is issued.
  - A button held through reset is re-debounced after reset and yields one btn_press.
- Synchroniser: two flops, btn_in -> sync1 -> sync2. Only sync2 feeds the FSM.
- States, all transitions evaluated at the rising edge:
  - IDLE (level 0): sync2=1 -> ARM_HIGH, cnt<=0; else stay.
  - ARM_HIGH (level 0):
    - sync2=0 -> IDLE, cnt<=0.
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> HIGH, btn_level<=1, btn_press<=1.
    - otherwise cnt<=cnt+1.
  - HIGH (level 1): sync2=0 -> ARM_LOW, cnt<=0; else stay.
  - ARM_LOW (level 1):
    - sync2=1 -> HIGH, cnt<=0.
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0, btn_release<=1.
    - otherwise cnt<=cnt+1.
- Pulses: btn_press and btn_release are high for exactly one cycle, cleared at the next edge. They can never be high in the same cycle.
- Latency, with edge 0 being the first edge that samples btn_in=1:
  - btn_level and btn_press are high after edge DEBOUNCE_CYCLES+2, provided btn_in stays high.
  - Release is symmetric.
- Glitch rejection:
  - Any sync2 excursion shorter than DEBOUNCE_CYCLES samples returns to the stable state with no output change and no pulse.
  - Counting restarts from 0 on every bounce.
- Counter: never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is held (not cleared) only in the stable states, where its value is unused.
- DEBOUNCE_CYCLES=1: acceptance occurs one edge after entering ARM_*; the latency formula still holds.

Decomposition:
- button_pkg:
  - typedef enum logic [1:0] btn_state_t {IDLE, ARM_HIGH, HIGH, ARM_LOW};
  - localparam default debounce count.
- One sub-module, sync_2ff (parameterised reset value, default 0, reset by rst_n), instantiated for btn_in.
- FSM and counter stay in button_conditioner.

Test Plan:
- All cases use DEBOUNCE_CYCLES=4.
- Clean press: rst_n=0 for 2 cycles, release; btn_in 0->1 before edge 0 and held -> btn_press=1 only in the cycle after edge 6; btn_level=1 from edge 6; nbtn_level=0.
- Bounce rejection: btn_in pattern 1,1,0,1,1,1,0 then 0 (one sample per cycle) -> btn_level stays 0; btn_press never asserts; state returns to IDLE.
- Bounce then settle: btn_in 1,0,1 then held 1 -> exactly one btn_press, 6 edges after the final 0->1 sample; no second pulse while held for 20 cycles.
- Clean release: from HIGH, btn_in 1->0 held -> btn_release=1 for one cycle after edge 6 relative to the first 0 sample; btn_level=0; btn_press stays 0.
- Reset mid-count: btn_in=1; assert rst_n=0 at edge 4 (state ARM_HIGH, cnt=2) -> all outputs 0; after rst_n=1 with btn_in still 1, btn_press fires 6 edges later, once.
- Reset while HIGH: rst_n=0 with btn_level=1 -> btn_level=0 at that edge; btn_release never pulses.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioner.
package button_pkg;

    // 10 ms at 100 MHz.
    localparam int unsigned DefaultDebounceCycles = 1000000;

    typedef enum logic [1:0] {
        IDLE,
        ARM_HIGH,
        HIGH,
        ARM_LOW
    } btn_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous input into the clk domain.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;

    always_comb begin
        sync1_d = d_i;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q_o = sync2_q;

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw button pin; emits a clean level plus
// one-cycle press and release pulses.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic nbtn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_sync;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (btn_in),
        .q_o  (btn_sync)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = ARM_HIGH;
                    cnt_d   = '0;
                end
            end
            ARM_HIGH: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!btn_sync) begin
                    state_d = ARM_LOW;
                    cnt_d   = '0;
                end
            end
            ARM_LOW: begin
                if (btn_sync) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // Reset discards any debounce progress and never emits a release pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign nbtn_level  = ~level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule
